// File: rtl/memory_bus_arbiter_if.sv
// memory_bus_arbiter_if
//   Request/response bus shared by the two core masters and by the
//   controller-facing memory port of memory_bus_arbiter.
//
//   Signals
//     read_request, write_request : access request, held until response
//     addr, write_data            : access address / write payload
//     read_data                   : returned read data, valid with response
//     response                    : completion
//     error                       : qualifies response (access aborted)
//
//   Modports
//     master : the side issuing accesses (a core bus)
//     slave  : the side serving accesses (arbiter toward a core master)
//     ctrl   : arbiter toward the controller; the controller reports no
//              error, so that signal is left out of this view
interface memory_bus_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  read_request;
  logic                  write_request;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] write_data;
  logic [DATA_WIDTH-1:0] read_data;
  logic                  response;
  logic                  error;

  modport master (
    output read_request, write_request, addr, write_data,
    input  read_data, response, error
  );

  modport slave (
    input  read_request, write_request, addr, write_data,
    output read_data, response, error
  );

  modport ctrl (
    output read_request, write_request, addr, write_data,
    input  read_data, response
  );
endinterface

// File: rtl/memory_bus_arbiter.sv
// memory_bus_arbiter
//   Shares one controller memory port between an instruction master (m0)
//   and a data master (m1). Accesses are registered, masters are granted
//   round-robin on contention, and a watchdog aborts accesses the memory
//   never answers.
//
//   Ports
//     clk    : single clock, rising edge
//     reset  : synchronous, active-high
//     m0     : instruction master bus (slave view)
//     m1     : data master bus (slave view)
//     mem    : controller port (ctrl view); requests registered
//     grant  : one-hot current owner {m1, m0}; 2'b00 when idle
//
//   State  | Meaning
//   -------+---------------------------------------------------------------
//   IDLE   | no owner; arbitrate and latch the winner's access into mem_*
//   ACCESS | mem_* held constant, waiting for mem.response or watchdog
//   DONE   | owner's response pulse (error if aborted); update last_grant
module memory_bus_arbiter #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                 clk,
  input  logic                 reset,
  memory_bus_arbiter_if.slave  m0,
  memory_bus_arbiter_if.slave  m1,
  memory_bus_arbiter_if.ctrl   mem,
  output logic [1:0]           grant
);

  localparam int WD_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam bit WD_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t                state;
  logic                  owner;       // 0 = m0, 1 = m1
  logic                  last_grant;  // 0 = m0, 1 = m1
  logic [WD_W-1:0]       wdog;

  logic                  mem_rd_q;
  logic                  mem_wr_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [DATA_WIDTH-1:0] mem_wdata_q;

  logic [DATA_WIDTH-1:0] rdata0_q;
  logic [DATA_WIDTH-1:0] rdata1_q;
  logic                  resp0_q;
  logic                  resp1_q;
  logic                  err0_q;
  logic                  err1_q;
  logic [1:0]            grant_q;

  logic                  req0;
  logic                  req1;
  logic                  pick1;
  logic                  sel_rd;
  logic                  sel_wr;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic [DATA_WIDTH-1:0] rdata_cap;

  // Arbitration: a lone requester wins; on contention the master that was
  // not granted last wins.
  always_comb begin
    req0      = m0.read_request | m0.write_request;
    req1      = m1.read_request | m1.write_request;
    pick1     = req1 & (~req0 | ~last_grant);
    sel_rd    = pick1 ? m1.read_request  : m0.read_request;
    sel_wr    = pick1 ? m1.write_request : m0.write_request;
    sel_addr  = pick1 ? m1.addr          : m0.addr;
    sel_wdata = pick1 ? m1.write_data    : m0.write_data;
    // Writes return no data; the master sees 0.
    rdata_cap = mem_wr_q ? '0 : mem.read_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      owner       <= 1'b0;
      last_grant  <= 1'b1;
      wdog        <= '0;
      mem_rd_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
      resp0_q     <= 1'b0;
      resp1_q     <= 1'b0;
      err0_q      <= 1'b0;
      err1_q      <= 1'b0;
      grant_q     <= 2'b00;
    end else begin
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            owner       <= pick1;
            grant_q     <= pick1 ? 2'b10 : 2'b01;
            // Read and write together on one master collapses to a write.
            mem_wr_q    <= sel_wr;
            mem_rd_q    <= sel_rd & ~sel_wr;
            mem_addr_q  <= sel_addr;
            mem_wdata_q <= sel_wdata;
            wdog        <= WD_W'(1);
            state       <= ACCESS;
          end
        end

        ACCESS: begin
          // A response on the timeout cycle still completes normally.
          if (mem.response) begin
            mem_rd_q <= 1'b0;
            mem_wr_q <= 1'b0;
            if (owner) begin
              rdata1_q <= rdata_cap;
              resp1_q  <= 1'b1;
              err1_q   <= 1'b0;
            end else begin
              rdata0_q <= rdata_cap;
              resp0_q  <= 1'b1;
              err0_q   <= 1'b0;
            end
            state <= DONE;
          end else if (WD_EN && (wdog == WD_LIMIT)) begin
            mem_rd_q <= 1'b0;
            mem_wr_q <= 1'b0;
            if (owner) begin
              rdata1_q <= '0;
              resp1_q  <= 1'b1;
              err1_q   <= 1'b1;
            end else begin
              rdata0_q <= '0;
              resp0_q  <= 1'b1;
              err0_q   <= 1'b1;
            end
            state <= DONE;
          end else if (WD_EN) begin
            wdog <= wdog + WD_W'(1);
          end
        end

        DONE: begin
          resp0_q    <= 1'b0;
          resp1_q    <= 1'b0;
          err0_q     <= 1'b0;
          err1_q     <= 1'b0;
          rdata0_q   <= '0;
          rdata1_q   <= '0;
          grant_q    <= 2'b00;
          last_grant <= owner;
          wdog       <= '0;
          state      <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign mem.read_request  = mem_rd_q;
  assign mem.write_request = mem_wr_q;
  assign mem.addr          = mem_addr_q;
  assign mem.write_data    = mem_wdata_q;

  assign m0.read_data = rdata0_q;
  assign m0.response  = resp0_q;
  assign m0.error     = err0_q;
  assign m1.read_data = rdata1_q;
  assign m1.response  = resp1_q;
  assign m1.error     = err1_q;

  assign grant = grant_q;

endmodule

// File: tb/tb_memory_bus_arbiter.sv
module tb_memory_bus_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] grant;

  memory_bus_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) m0_if ();
  memory_bus_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) m1_if ();
  memory_bus_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) mem_if ();

  memory_bus_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset(reset),
    .m0(m0_if), .m1(m1_if), .mem(mem_if),
    .grant(grant)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        r0, w0;
    logic [31:0] a0, d0;
    logic        r1, w1;
    logic [31:0] a1, d1;
    int          wt;        // memory wait cycles
    logic        m1_first;  // expected winner on contention
  } vec_t;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          cyc;
  } rsp_t;

  typedef struct {
    logic        wr;
    logic        rd;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  gnt;
  } mem_t;

  rsp_t sb0[$];
  rsp_t sb1[$];
  mem_t memq[$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int resp_seen = 0;

  logic pend0, pend1;
  int   mem_wait = 0;
  logic mem_mute = 1'b0;
  logic force_resp = 1'b0;
  logic mem_busy = 1'b0;
  int   mem_cnt = 0;
  logic [31:0] cap_addr, cap_wdata;
  logic cap_rd, cap_wr;

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    if (a == 32'h100) return 32'hCAFE_BABE;
    return {a[15:0], ~a[15:0]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic mon_master(input int id);
    logic r, e, orr, oe;
    logic [31:0] d, od;
    rsp_t x;
    if (id == 0) begin
      r = m0_if.response; e = m0_if.error; d = m0_if.read_data;
      orr = m1_if.response; oe = m1_if.error; od = m1_if.read_data;
    end else begin
      r = m1_if.response; e = m1_if.error; d = m1_if.read_data;
      orr = m0_if.response; oe = m0_if.error; od = m0_if.read_data;
    end
    if (r) begin
      resp_seen++;
      check($sformatf("m%0d_other_quiet", id), {30'd0, orr, oe} | od, 32'd0);
      if ((id == 0 && sb0.size() == 0) || (id == 1 && sb1.size() == 0)) begin
        check($sformatf("m%0d_unexpected_response", id), 32'd1, 32'd0);
      end else begin
        x = (id == 0) ? sb0.pop_front() : sb1.pop_front();
        check($sformatf("m%0d_read_data", id), d, x.data);
        check($sformatf("m%0d_error", id), 32'(e), 32'(x.err));
        check($sformatf("m%0d_latency", id), 32'(cyc), 32'(x.cyc));
      end
      // Requester drops its request while the response is showing.
      if (id == 0) begin
        m0_if.read_request = 1'b0; m0_if.write_request = 1'b0; pend0 = 1'b0;
      end else begin
        m1_if.read_request = 1'b0; m1_if.write_request = 1'b0; pend1 = 1'b0;
      end
    end
  endtask

  task automatic mem_model();
    mem_t x;
    mem_if.response  = 1'b0;
    mem_if.read_data = '0;
    if (force_resp) begin
      mem_if.response  = 1'b1;
      mem_if.read_data = 32'hFFFF_FFFF;
      force_resp = 1'b0;
    end else if (mem_if.read_request || mem_if.write_request) begin
      if (!mem_busy) begin
        mem_busy = 1'b1; mem_cnt = 0;
        cap_addr = mem_if.addr; cap_wdata = mem_if.write_data;
        cap_rd = mem_if.read_request; cap_wr = mem_if.write_request;
      end else begin
        mem_cnt++;
        check("mem_addr_stable", mem_if.addr, cap_addr);
        check("mem_req_stable", {30'd0, mem_if.read_request, mem_if.write_request},
              {30'd0, cap_rd, cap_wr});
      end
      if (!mem_mute && mem_cnt == mem_wait) begin
        mem_if.response  = 1'b1;
        mem_if.read_data = mem_fn(mem_if.addr);
        if (memq.size() == 0) begin
          check("mem_unexpected_access", 32'd1, 32'd0);
        end else begin
          x = memq.pop_front();
          check("mem_addr", mem_if.addr, x.addr);
          check("mem_rd_wr", {30'd0, mem_if.read_request, mem_if.write_request},
                {30'd0, x.rd, x.wr});
          if (x.wr) check("mem_write_data", mem_if.write_data, x.wdata);
          check("grant", 32'(grant), 32'(x.gnt));
        end
      end
    end else begin
      mem_busy = 1'b0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    mon_master(0);
    mon_master(1);
    mem_model();
  endtask

  task automatic push_exp(input int id, input logic r, input logic w,
                          input logic [31:0] a, input logic [31:0] d, input int lat);
    rsp_t s;
    mem_t m;
    s.data = w ? 32'd0 : mem_fn(a);
    s.err  = 1'b0;
    s.cyc  = cyc + lat;
    if (id == 0) sb0.push_back(s); else sb1.push_back(s);
    m.wr = w; m.rd = r & ~w; m.addr = a; m.wdata = d;
    m.gnt = (id == 0) ? 2'b01 : 2'b10;
    memq.push_back(m);
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    logic q0, q1, first1;
    int n;
    q0 = v.r0 | v.w0;
    q1 = v.r1 | v.w1;
    first1 = q1 && (!q0 || v.m1_first);
    mem_wait = v.wt;
    if (first1) begin
      push_exp(1, v.r1, v.w1, v.a1, v.d1, v.wt + 2);
      if (q0) push_exp(0, v.r0, v.w0, v.a0, v.d0, 2 * v.wt + 5);
    end else begin
      if (q0) push_exp(0, v.r0, v.w0, v.a0, v.d0, v.wt + 2);
      if (q1) push_exp(1, v.r1, v.w1, v.a1, v.d1, 2 * v.wt + 5);
    end
    m0_if.read_request = v.r0; m0_if.write_request = v.w0;
    m0_if.addr = v.a0; m0_if.write_data = v.d0;
    m1_if.read_request = v.r1; m1_if.write_request = v.w1;
    m1_if.addr = v.a1; m1_if.write_data = v.d1;
    pend0 = q0;
    pend1 = q1;
    n = 0;
    while ((pend0 || pend1) && n < 60) begin
      step();
      n++;
    end
    check({tag, "_completed"}, {30'd0, pend0, pend1}, 32'd0);
    step();
    check({tag, "_grant_idle"}, 32'(grant), 32'd0);
    check({tag, "_queues_empty"}, 32'(sb0.size() + sb1.size() + memq.size()), 32'd0);
  endtask

  vec_t vecs[8];

  initial begin
    #200000;
    $display("FAIL global_time_limit: got timeout expected completion");
    $fatal(1, "time limit");
  end

  initial begin
    int n;
    vec_t pr;

    //          r0    w0    a0           d0            r1    w1    a1           d1            wt m1_first
    vecs[0] = '{1'b1, 1'b0, 32'h1000,    32'h0,        1'b0, 1'b1, 32'h2000,    32'h1234_5678, 0, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 32'h100,     32'h0,        1'b0, 1'b0, 32'h0,       32'h0,         0, 1'b0};
    vecs[2] = '{1'b1, 1'b0, 32'h1008,    32'h0,        1'b0, 1'b1, 32'h2008,    32'hDEAD_BEEF, 1, 1'b1};
    vecs[3] = '{1'b0, 1'b0, 32'h0,       32'h0,        1'b1, 1'b0, 32'h3000,    32'h0,         3, 1'b0};
    vecs[4] = '{1'b1, 1'b1, 32'h40,      32'hA5A5_A5A5, 1'b1, 1'b0, 32'h44,     32'h0,         2, 1'b0};
    vecs[5] = '{1'b1, 1'b0, 32'h500,     32'h0,        1'b0, 1'b0, 32'h0,       32'h0,         7, 1'b0};
    vecs[6] = '{1'b0, 1'b0, 32'h0,       32'h0,        1'b0, 1'b1, 32'h600,     32'h0BAD_F00D, 5, 1'b0};
    vecs[7] = '{1'b1, 1'b0, 32'h700,     32'h0,        1'b1, 1'b0, 32'h704,     32'h0,         5, 1'b0};

    reset = 1'b1;
    pend0 = 1'b0; pend1 = 1'b0;
    m0_if.read_request = 1'b0; m0_if.write_request = 1'b0; m0_if.addr = '0; m0_if.write_data = '0;
    m1_if.read_request = 1'b0; m1_if.write_request = 1'b0; m1_if.addr = '0; m1_if.write_data = '0;
    mem_if.response = 1'b0; mem_if.read_data = '0; mem_if.error = 1'b0;
    step(); step(); step();
    check("reset_m0", {30'd0, m0_if.response, m0_if.error} | m0_if.read_data, 32'd0);
    check("reset_m1", {30'd0, m1_if.response, m1_if.error} | m1_if.read_data, 32'd0);
    check("reset_mem_req", {30'd0, mem_if.read_request, mem_if.write_request}, 32'd0);
    check("reset_mem_addr_data", mem_if.addr | mem_if.write_data, 32'd0);
    check("reset_grant", 32'(grant), 32'd0);
    reset = 1'b0;
    step();

    for (int i = 0; i < 8; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
    end

    // Memory never answers: watchdog aborts with an error.
    mem_mute = 1'b1;
    begin
      rsp_t s;
      s.data = 32'd0; s.err = 1'b1; s.cyc = cyc + TO + 1;
      sb0.push_back(s);
    end
    m0_if.read_request = 1'b1; m0_if.addr = 32'h800; m0_if.write_data = 32'h0;
    pend0 = 1'b1;
    n = 0;
    while (pend0 && n < 40) begin
      step();
      n++;
    end
    check("timeout_completed", 32'(pend0), 32'd0);
    check("timeout_mem_read_low", 32'(mem_if.read_request), 32'd0);
    step();
    check("timeout_grant_idle", 32'(grant), 32'd0);

    // Reset in the middle of an access abandons it silently.
    m0_if.read_request = 1'b1; m0_if.addr = 32'h900;
    step(); step(); step();
    check("rst_mid_in_access", {30'd0, mem_if.read_request, mem_if.write_request}, 32'd2);
    reset = 1'b1;
    m0_if.read_request = 1'b0;
    step();
    check("rst_mid_m0", {30'd0, m0_if.response, m0_if.error} | m0_if.read_data, 32'd0);
    check("rst_mid_m1", {30'd0, m1_if.response, m1_if.error} | m1_if.read_data, 32'd0);
    check("rst_mid_mem", {30'd0, mem_if.read_request, mem_if.write_request}, 32'd0);
    check("rst_mid_grant", 32'(grant), 32'd0);
    reset = 1'b0;
    mem_mute = 1'b0;
    n = resp_seen;
    force_resp = 1'b1;
    step(); step(); step(); step();
    check("rst_late_mem_response_ignored", 32'(resp_seen - n), 32'd0);

    // last_grant is back to m1 after reset, so m0 wins the first contention.
    pr = '{1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b1, 32'h14, 32'h55, 0, 1'b0};
    run_vec(pr, "post_reset_pair");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/memory_bus_arbiter.md
# memory_bus_arbiter

Two-master, one-slave arbiter that shares the single Controller memory port (`core_*_memory`) between an instruction master (m0) and a data master (m1). It is placed between a core with split instruction and data buses and the Controller. It registers every access, grants masters round-robin, and aborts accesses the memory never answers by using a watchdog.

## Interface
- `ADDR_WIDTH`, 32, address width on all ports
- `DATA_WIDTH`, 32, data width on all ports
- `TIMEOUT_CYCLES`, 1024, maximum number of cycles spent waiting for `mem_response`; 0 disables the watchdog
- `clk`  in  1  single clock, all logic on rising edge
- `reset`  in  1  synchronous, active-high
- `m0_read_request`, `m0_write_request`  in  1 each  m0 access request; held until `m0_response`
- `m0_addr`  in  ADDR_WIDTH  m0 address
- `m0_write_data`  in  DATA_WIDTH  m0 write data
- `m0_read_data`  out  DATA_WIDTH  registered read data; valid while `m0_response`=1
- `m0_response`  out  1  one-cycle completion pulse
- `m0_error`  out  1  qualifies `m0_response`: access timed out
- `m1_*`  same set as m0, for the data master
- `mem_read_request`, `mem_write_request`  out  1 each  registered request to the Controller
- `mem_addr`  out  ADDR_WIDTH  registered address to the Controller
- `mem_write_data`  out  DATA_WIDTH  registered write data to the Controller
- `mem_read_data`  in  DATA_WIDTH  Controller read data; sampled when `mem_response`=1
- `mem_response`  in  1  Controller completion
- `grant`  out  2  one-hot current owner; 2'b00 when idle

## Operation
- FSM states: IDLE, ACCESS, DONE.
- IDLE: a master is requesting if its read or write request is high.
  - With exactly one requester, that master is granted.
  - With both requesting, the master not granted last wins. `last_grant` resets to m1, so m0 wins the first contention.
  - On grant, the arbiter latches addr, write data and request type into the `mem_*` outputs and goes to ACCESS.
  - If both read and write are high on one master, the arbiter performs a write only.
- ACCESS: `mem_*` outputs are held constant.
  - When `mem_response`=1, the arbiter captures `mem_read_data` into the owner's read_data register, drops `mem_*_request`, and goes to DONE.
  - If the watchdog reaches TIMEOUT_CYCLES with no `mem_response`, the arbiter drops the request, sets the owner's read_data to 0, sets the error flag, and goes to DONE.
- DONE: the owner's `m*_response` is 1 for this cycle only, with `m*_error` as set. The non-owner's outputs stay 0. Next state is IDLE and `last_grant` is updated.
- Read data for writes: undefined; the arbiter drives 0.
- A request from the non-owner during ACCESS or DONE waits; it is never dropped.
- Requester rule: a master deasserts or changes its request in the cycle after its response. A request still high in IDLE is treated as a new access.
- `mem_response` arriving in IDLE or DONE is ignored.

## Timing
- Reset values: all `mem_*` outputs 0, `m*_read_data` 0, `m*_response` 0, `m*_error` 0, `grant` 0. State is IDLE, watchdog 0, `last_grant`=m1.
- Reset mid-access: the arbiter returns to IDLE next cycle, no response is issued, and the pending access is abandoned.
- Latency:
  - Request high in IDLE cycle t → `mem_*_request` high from t+1.
  - `mem_response` at cycle r → `m*_response` at r+1.
  - Minimum case (`mem_response` at t+1): response at t+2, next grant evaluated at t+3.
- Watchdog: counts ACCESS cycles starting at 1 on the first ACCESS cycle. Timeout fires on the cycle the count equals TIMEOUT_CYCLES and `mem_response` is still 0. `mem_response` in that same cycle wins and no error is flagged.
- Throughput: one access per at least 3 cycles; there is no pipelining.

## Test plan
- Single m0 read: addr 0x100, memory answers 0xCAFEBABE one cycle after the request → `m0_response` at t+2 with data 0xCAFEBABE; `mem_addr`=0x100; m1 outputs stay 0.
- Simultaneous m0 read and m1 write (0x2000 ← 0x12345678), both held → m0 is served first, then m1. Memory sees a write with 0x12345678. A second simultaneous pair is served m1 first (round-robin).
- m1 holds its request while m0's access takes 5 wait cycles → `mem_addr` stays stable throughout; m1 is granted on the IDLE cycle after m0's DONE.
- TIMEOUT_CYCLES=8, memory never responds → `m0_response`=1 and `m0_error`=1 at the 8th ACCESS cycle +1, read data 0, `mem_read_request` low after the abort.
- Reset asserted during ACCESS → next cycle all outputs are 0 and `grant`=0. A later `mem_response` produces no master response.
- m0 asserts read and write together (addr 0x40, data 0xA5A5A5A5) → the memory sees only a write of 0xA5A5A5A5 to 0x40, and `m0_read_data`=0 on response.
